// File: rtl/compact_queue_if.sv
// ---------------------------------------------------------------------------
// compact_queue_if
// Bus bundle between a compact_queue and its user.
//
// Signals (direction as seen by the queue, i.e. the slave modport):
//   flush      in   synchronous clear of all entries
//   wr_valid   in   write request
//   wr_data    in   write data
//   wr_ready   out  write accepted when high together with wr_valid
//   rd_en      in   read-and-remove request
//   rd_sel     in   one-hot entry index to read
//   rd_valid   out  one-cycle pulse, rd_data valid
//   rd_data    out  read data (held between reads)
//   rd_err     out  one-cycle pulse, illegal read
//   status     out  occupancy bitmap
//   count      out  number of stored entries
//   full       out  count == DEPTH
//   empty      out  count == 0
//   match_key  in   search key
//   match_vec  out  per-entry equality hits
//   match_any  out  OR of match_vec
// ---------------------------------------------------------------------------
interface compact_queue_if #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
);
   logic                  flush;
   logic                  wr_valid;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ready;
   logic                  rd_en;
   logic [DEPTH-1:0]      rd_sel;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_err;
   logic [DEPTH-1:0]      status;
   logic [CNT_WIDTH-1:0]  count;
   logic                  full;
   logic                  empty;
   logic [DATA_WIDTH-1:0] match_key;
   logic [DEPTH-1:0]      match_vec;
   logic                  match_any;

   modport master (
      output flush, wr_valid, wr_data, rd_en, rd_sel, match_key,
      input  wr_ready, rd_valid, rd_data, rd_err, status, count, full, empty,
             match_vec, match_any
   );

   modport slave (
      input  flush, wr_valid, wr_data, rd_en, rd_sel, match_key,
      output wr_ready, rd_valid, rd_data, rd_err, status, count, full, empty,
             match_vec, match_any
   );
endinterface

// File: rtl/compact_queue.sv
// ---------------------------------------------------------------------------
// compact_queue
// Packed entry store: entries always occupy indices 0..count-1 with index 0
// the oldest. Any entry can be read-and-removed by a one-hot select; the
// entries above it slide down one slot so the store stays packed. New data is
// appended at the top. A per-entry equality search runs combinationally on
// the stored contents.
//
// Ports:
//   clk      in  clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      compact_queue_if.slave (write, read, status and search signals)
// ---------------------------------------------------------------------------
module compact_queue #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input logic            clk,
   input logic            reset_n,
   compact_queue_if.slave bus
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  rd_err_q, rd_err_d;

   logic [DEPTH-1:0]      status;
   logic [DEPTH-1:0]      shift_mask;
   logic [DEPTH-1:0]      match_vec;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [CNT_WIDTH-1:0]  wr_idx;
   logic                  full;
   logic                  sel_onehot;
   logic                  rd_legal;
   logic                  wr_acc;

   // Occupancy, full and ready all come from the registered count only.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         status[i] = (CNT_WIDTH'(i) < count_q);
      end
   end

   assign full = (count_q == CNT_WIDTH'(DEPTH));

   // x & (x-1) clears the lowest set bit; zero result means at most one bit.
   assign sel_onehot = (bus.rd_sel != '0) &&
                       ((bus.rd_sel & (bus.rd_sel - DEPTH'(1))) == '0);
   // A one-hot select that hits an occupied slot is exactly "p < count".
   assign rd_legal   = bus.rd_en & sel_onehot & (|(bus.rd_sel & status));
   assign wr_acc     = bus.wr_valid & ~full;
   // For a one-hot select this marks every index at or above p.
   assign shift_mask = ~(bus.rd_sel - DEPTH'(1));

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.rd_sel[i]) begin
            sel_data = sel_data | mem_q[i];
         end
      end
   end

   always_comb begin
      mem_d      = mem_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      rd_err_d   = 1'b0;
      // After a removal the top free slot is one lower.
      wr_idx     = rd_legal ? (count_q - CNT_WIDTH'(1)) : count_q;

      if (bus.flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
         end
         count_d = '0;
      end else begin
         if (rd_legal) begin
            // Slots above count are always zero, so shifting them down also
            // zeroes the vacated slot count-1.
            for (int i = 0; i < DEPTH - 1; i++) begin
               if (shift_mask[i]) begin
                  mem_d[i] = mem_q[i + 1];
               end
            end
            if (shift_mask[DEPTH-1]) begin
               mem_d[DEPTH-1] = '0;
            end
            rd_data_d  = sel_data;
            rd_valid_d = 1'b1;
         end
         rd_err_d = bus.rd_en & ~rd_legal;

         if (wr_acc) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (CNT_WIDTH'(i) == wr_idx) begin
                  mem_d[i] = bus.wr_data;
               end
            end
         end

         // wr_acc implies count < DEPTH, rd_legal implies count > 0.
         case ({wr_acc, rd_legal})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         match_vec[i] = status[i] & (mem_q[i] == bus.match_key);
      end
   end

   assign bus.wr_ready  = ~full;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_err    = rd_err_q;
   assign bus.status    = status;
   assign bus.count     = count_q;
   assign bus.full      = full;
   assign bus.empty     = (count_q == '0);
   assign bus.match_vec = match_vec;
   assign bus.match_any = |match_vec;

endmodule

// File: tb/tb_compact_queue.sv
// ---------------------------------------------------------------------------
// tb_compact_queue
// Bench for compact_queue (DEPTH=4, DATA_WIDTH=8). A queue-based reference
// model tracks the contents; a negedge process compares every output against
// it each cycle, and directed steps pin literal values.
// ---------------------------------------------------------------------------
module tb_compact_queue;
   localparam int DEPTH = 4;
   localparam int DW    = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic reset_n;
   logic chk_en = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   logic [DW-1:0] mq [$];
   logic [DW-1:0] m_rdata;
   logic          m_rvld;
   logic          m_rerr;

   compact_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

   compact_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_rdata = '0;
      m_rvld  = 1'b0;
      m_rerr  = 1'b0;
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, and
   // return just after the following falling edge.
   task automatic step(input logic fl, input logic wv, input logic [DW-1:0] wd,
                       input logic re, input logic [DEPTH-1:0] rs,
                       input logic [DW-1:0] mk);
      int  p;
      bit  legal;
      bit  wacc;
      bus.flush     = fl;
      bus.wr_valid  = wv;
      bus.wr_data   = wd;
      bus.rd_en     = re;
      bus.rd_sel    = rs;
      bus.match_key = mk;
      @(posedge clk);
      if (fl) begin
         mq.delete();
         m_rvld = 1'b0;
         m_rerr = 1'b0;
      end else begin
         wacc = wv && (mq.size() < DEPTH);
         p = DEPTH;
         for (int i = 0; i < DEPTH; i++) if (rs[i]) p = i;
         legal = re && ($countones(rs) == 1) && (p < mq.size());
         if (legal) begin
            m_rdata = mq[p];
            mq.delete(p);
         end
         m_rvld = legal;
         m_rerr = re && !legal;
         if (wacc) mq.push_back(wd);
      end
      @(negedge clk);
      #1;
   endtask

   // Continuous comparison against the model.
   always @(negedge clk) begin : compare
      logic [DEPTH-1:0] es;
      logic [DEPTH-1:0] em;
      if (chk_en && reset_n) begin
         es = '0;
         em = '0;
         for (int i = 0; i < DEPTH; i++) begin
            if (i < mq.size()) begin
               es[i] = 1'b1;
               em[i] = (mq[i] == bus.match_key);
            end
         end
         chk("count",     32'(bus.count),     32'(mq.size()));
         chk("status",    32'(bus.status),    32'(es));
         chk("full",      32'(bus.full),      32'(mq.size() == DEPTH));
         chk("empty",     32'(bus.empty),     32'(mq.size() == 0));
         chk("wr_ready",  32'(bus.wr_ready),  32'(mq.size() != DEPTH));
         chk("rd_valid",  32'(bus.rd_valid),  32'(m_rvld));
         chk("rd_err",    32'(bus.rd_err),    32'(m_rerr));
         chk("rd_data",   32'(bus.rd_data),   32'(m_rdata));
         chk("match_vec", 32'(bus.match_vec), 32'(em));
         chk("match_any", 32'(bus.match_any), 32'(em != '0));
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_count"},    32'(bus.count),    32'h0);
      chk({tag, "_status"},   32'(bus.status),   32'h0);
      chk({tag, "_full"},     32'(bus.full),     32'h0);
      chk({tag, "_empty"},    32'(bus.empty),    32'h1);
      chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'h0);
      chk({tag, "_rd_err"},   32'(bus.rd_err),   32'h0);
      chk({tag, "_rd_data"},  32'(bus.rd_data),  32'h0);
   endtask

   initial begin
      reset_n       = 1'b0;
      bus.flush     = 1'b0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;
      bus.rd_en     = 1'b0;
      bus.rd_sel    = '0;
      bus.match_key = '0;
      model_clear();
      #2;
      check_reset_outputs("por");
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // Fill to full, then a write while full is dropped.
      step(0, 1, 8'h11, 0, 4'b0000, 8'h00);
      step(0, 1, 8'h22, 0, 4'b0000, 8'h00);
      step(0, 1, 8'h33, 0, 4'b0000, 8'h00);
      step(0, 1, 8'h44, 0, 4'b0000, 8'h00);
      chk("fill_count",    32'(bus.count),    32'd4);
      chk("fill_status",   32'(bus.status),   32'hf);
      chk("fill_full",     32'(bus.full),     32'h1);
      chk("fill_wr_ready", 32'(bus.wr_ready), 32'h0);
      step(0, 1, 8'h55, 0, 4'b0000, 8'h55);
      chk("ovf_match_any", 32'(bus.match_any), 32'h0);
      chk("ovf_count",     32'(bus.count),     32'd4);
      bus.match_key = 8'h44;
      #1;
      chk("ovf_top_kept",  32'(bus.match_vec), 32'b1000);

      // Remove from the middle.
      step(0, 0, 8'h00, 1, 4'b0010, 8'h11);
      chk("mid_rd_data",  32'(bus.rd_data),   32'h22);
      chk("mid_rd_valid", 32'(bus.rd_valid),  32'h1);
      chk("mid_count",    32'(bus.count),     32'd3);
      chk("mid_status",   32'(bus.status),    32'b0111);
      chk("mid_head",     32'(bus.match_vec), 32'b0001);

      // Read head with simultaneous write.
      step(0, 1, 8'h66, 1, 4'b0001, 8'h66);
      chk("rw_rd_data", 32'(bus.rd_data),   32'h11);
      chk("rw_count",   32'(bus.count),     32'd3);
      chk("rw_append",  32'(bus.match_vec), 32'b0100);

      // Replace top so contents become {33,44,33}, then search.
      step(0, 1, 8'h33, 1, 4'b0100, 8'h33);
      chk("top_rd_data",   32'(bus.rd_data),   32'h66);
      chk("srch_vec",      32'(bus.match_vec), 32'b0101);
      chk("srch_any",      32'(bus.match_any), 32'h1);
      bus.match_key = 8'h99;
      #1;
      chk("srch_miss_vec", 32'(bus.match_vec), 32'h0);
      chk("srch_miss_any", 32'(bus.match_any), 32'h0);

      // Multi-hot select is illegal.
      step(0, 0, 8'h00, 1, 4'b0101, 8'h00);
      chk("mh_rd_err",   32'(bus.rd_err),   32'h1);
      chk("mh_rd_valid", 32'(bus.rd_valid), 32'h0);
      chk("mh_count",    32'(bus.count),    32'd3);
      chk("mh_rd_data",  32'(bus.rd_data),  32'h66);
      step(0, 0, 8'h00, 0, 4'b0000, 8'h00);
      chk("err_pulse", 32'(bus.rd_err), 32'h0);

      // Read while empty.
      step(1, 0, 8'h00, 0, 4'b0000, 8'h00);
      step(0, 0, 8'h00, 1, 4'b0001, 8'h00);
      chk("empty_rd_err",   32'(bus.rd_err),   32'h1);
      chk("empty_rd_valid", 32'(bus.rd_valid), 32'h0);
      chk("empty_count",    32'(bus.count),    32'd0);

      // Flush wins over read and write on a full queue.
      step(0, 1, 8'haa, 0, 4'b0000, 8'h00);
      step(0, 1, 8'hbb, 0, 4'b0000, 8'h00);
      step(0, 1, 8'hcc, 0, 4'b0000, 8'h00);
      step(0, 1, 8'hdd, 0, 4'b0000, 8'h00);
      step(1, 1, 8'hee, 1, 4'b0001, 8'hee);
      chk("fl_count",    32'(bus.count),     32'd0);
      chk("fl_empty",    32'(bus.empty),     32'h1);
      chk("fl_rd_valid", 32'(bus.rd_valid),  32'h0);
      chk("fl_rd_err",   32'(bus.rd_err),    32'h0);
      chk("fl_rd_data",  32'(bus.rd_data),   32'h66);
      chk("fl_match",    32'(bus.match_any), 32'h0);

      // Write while full is ignored even with a legal read.
      step(0, 1, 8'h01, 0, 4'b0000, 8'h00);
      step(0, 1, 8'h02, 0, 4'b0000, 8'h00);
      step(0, 1, 8'h03, 0, 4'b0000, 8'h00);
      step(0, 1, 8'h04, 0, 4'b0000, 8'h00);
      step(0, 1, 8'h09, 1, 4'b0001, 8'h09);
      chk("fullrw_rd_data", 32'(bus.rd_data),   32'h01);
      chk("fullrw_count",   32'(bus.count),     32'd3);
      chk("fullrw_nowrite", 32'(bus.match_any), 32'h0);

      // Asynchronous reset with a read result in flight.
      reset_n = 1'b0;
      model_clear();
      #1;
      check_reset_outputs("mid_rst");
      @(posedge clk);
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      step(0, 1, 8'hab, 0, 4'b0000, 8'hab);
      chk("post_rst_idx0", 32'(bus.match_vec), 32'b0001);
      chk("post_rst_cnt",  32'(bus.count),     32'd1);

      // Randomised traffic.
      for (int n = 0; n < 2000; n++) begin
         logic             fl, wv, re;
         logic [DW-1:0]    wd, mk;
         logic [DEPTH-1:0] rs;
         fl = ($urandom_range(0, 99) < 3);
         wv = ($urandom_range(0, 99) < 60);
         re = ($urandom_range(0, 99) < 45);
         wd = DW'($urandom_range(0, 7));
         mk = DW'($urandom_range(0, 7));
         if ($urandom_range(0, 9) < 7) rs = DEPTH'(1) << $urandom_range(0, DEPTH - 1);
         else                         rs = DEPTH'($urandom_range(0, 15));
         step(fl, wv, wd, re, rs, mk);
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/compact_queue.md
COMPACT_QUEUE -- requirements
Module: compact_queue

Interface
REQ-001 The block SHALL take parameter DEPTH, default 8, as the number of entries (legal range 2..64).
REQ-002 The block SHALL take parameter DATA_WIDTH, default 8, as the entry width in bits.
REQ-003 The block SHALL take parameter CNT_WIDTH, default $clog2(DEPTH+1), as the width of count.
REQ-004 clk  in  1  clock, all state updates on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  synchronous clear of all entries.
REQ-007 wr_valid  in  1  write request; wr_data  in  DATA_WIDTH  write data; wr_ready  out  1  write accepted this cycle when high with wr_valid.
REQ-008 rd_en  in  1  read-and-remove request; rd_sel  in  DEPTH  one-hot entry index to read.
REQ-009 rd_valid  out  1  one-cycle pulse, rd_data valid; rd_data  out  DATA_WIDTH  read data; rd_err  out  1  one-cycle pulse, illegal read.
REQ-010 status  out  DEPTH  occupancy bitmap; count  out  CNT_WIDTH  number of stored entries; full  out  1; empty  out  1.
REQ-011 match_key  in  DATA_WIDTH  search key; match_vec  out  DEPTH  per-entry equality hits; match_any  out  1  OR of match_vec.

Function
REQ-012 Entries SHALL always be packed at indices 0..count-1, index 0 the oldest.
REQ-013 status[i] SHALL equal (i < count) at all times; full = (count == DEPTH); empty = (count == 0).
REQ-014 wr_ready SHALL equal ~full, derived from registered count only (no combinational path from rd_en).
REQ-015 An accepted write alone (wr_valid & wr_ready, no legal read) SHALL store wr_data at index count and increment count by 1.
REQ-016 A read SHALL be legal when rd_sel has exactly one bit set at index p with p < count.
REQ-017 A legal read SHALL, on the same edge: register entry p into rd_data, pulse rd_valid, shift entries p+1..count-1 down by one, zero the vacated index count-1, and decrement count by 1.
REQ-018 An illegal read (rd_sel zero, multi-hot, or p >= count, including any read while empty) SHALL pulse rd_err, leave storage, count and rd_data unchanged, and keep rd_valid low.
REQ-019 Legal read plus accepted write in the same cycle SHALL remove entry p as REQ-017, append wr_data at index count-1 after compaction, and leave count unchanged.
REQ-020 Illegal read plus accepted write SHALL perform the write alone (REQ-015) and pulse rd_err.
REQ-021 wr_valid while full SHALL be ignored with no error, even if a legal read occurs in the same cycle.
REQ-022 Read latency SHALL be one cycle: rd_data/rd_valid visible the cycle after the rd_en edge; rd_data holds its last value otherwise.
REQ-023 flush SHALL take priority over read and write: count := 0, all entries zeroed, rd_valid and rd_err low that cycle, rd_data held.
REQ-024 match_vec[i] SHALL equal status[i] & (entry[i] == match_key), combinational from registered storage; match_any = |match_vec.
REQ-025 count arithmetic SHALL never wrap: count stays within 0..DEPTH under every input combination.

Reset
REQ-026 While reset_n is low, regardless of clk: count = 0, status = 0, full = 0, empty = 1, rd_valid = 0, rd_err = 0, rd_data = 0, all entries = 0.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries and any in-flight read result; first accepted write after release lands at index 0.
REQ-028 Deassertion of reset_n SHALL be synchronised externally; the block requires no idle cycles after release.

Verification (DEPTH=4, DATA_WIDTH=8)
REQ-029 Write 0x11,0x22,0x33,0x44 -> count=4, status=4'b1111, full=1, wr_ready=0; fifth write 0x55 ignored, contents unchanged.
REQ-030 From {0x11,0x22,0x33,0x44}, rd_sel=4'b0010 -> next cycle rd_data=0x22, rd_valid=1; contents {0x11,0x33,0x44}, count=3, status=4'b0111.
REQ-031 From {0x11,0x33,0x44}, rd_sel=4'b0001 with write 0x66 -> rd_data=0x11; contents {0x33,0x44,0x66}, count=3.
REQ-032 Empty queue, rd_sel=4'b0001 -> rd_err=1 for one cycle, rd_valid=0, count=0; rd_sel=4'b0101 with count=3 -> rd_err=1, no change.
REQ-033 Contents {0x33,0x44,0x33}, match_key=0x33 -> match_vec=4'b0101, match_any=1; match_key=0x99 -> match_vec=0, match_any=0.
REQ-034 Full queue, flush with simultaneous rd_en and wr_valid -> count=0, empty=1, rd_valid=0; reset_n pulsed low mid-stream -> all outputs at REQ-026 values immediately.
